// File: rtl/sort_n_seq.sv
// Purpose : sequential odd-even transposition sorter for N unsigned W-bit elements, asc/desc per job.
// Latency : load edge t0, one pass per edge t0+1..t0+N, out_valid from edge t0+N (fewer with early exit).
// Backpres: result held in DONE until out_ready; in_ready only in IDLE, no input queueing.
// Optional: define SORT_EARLY_EXIT_EN to leave SORT after two consecutive swap-free passes.
module sort_n_seq #(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  input  logic           desc,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_data,
  output logic           busy
);

  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST_PASS = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SORT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [W-1:0]     r_e     [N];
  logic [W-1:0]     w_e_nxt [N];
  logic [CNT_W-1:0] r_pass;
  logic             r_desc;
  logic             w_load;
  logic             w_last_pass;
  logic             w_exit;
`ifdef SORT_EARLY_EXIT_EN
  logic             w_any_swap;
  logic             r_prev_clean;
`endif

  assign w_load      = in_valid && (r_state == S_IDLE);
  assign w_last_pass = (r_pass == LAST_PASS);

`ifdef SORT_EARLY_EXIT_EN
  // An even and an odd pass that both swap nothing prove the array is ordered.
  assign w_exit = w_last_pass || (!w_any_swap && r_prev_clean);
`else
  assign w_exit = w_last_pass;
`endif

  // One transposition pass: even passes pair (0,1),(2,3)..., odd passes (1,2),(3,4)...
  always_comb begin
    w_e_nxt = r_e;
`ifdef SORT_EARLY_EXIT_EN
    w_any_swap = 1'b0;
`endif
    for (int i = 0; i < N - 1; i++) begin
      if (i[0] == r_pass[0]) begin
        // Strict compares keep equal elements in place, so the sort is stable.
        if (r_desc ? (r_e[i] < r_e[i+1]) : (r_e[i] > r_e[i+1])) begin
          w_e_nxt[i]   = r_e[i+1];
          w_e_nxt[i+1] = r_e[i];
`ifdef SORT_EARLY_EXIT_EN
          w_any_swap = 1'b1;
`endif
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; reset abandons any job in flight.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_load) w_state_nxt = S_SORT;
      S_SORT: if (w_exit) w_state_nxt = S_DONE;
      S_DONE: if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Element registers, pass counter and latched direction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        r_e[i] <= '0;
      end
      r_pass <= '0;
      r_desc <= 1'b0;
    end else if (w_load) begin
      for (int i = 0; i < N; i++) begin
        r_e[i] <= in_data[W*i +: W];
      end
      r_pass <= '0;
      r_desc <= desc;
    end else if (r_state == S_SORT) begin
      r_e <= w_e_nxt;
      // Hold at the last pass index so the counter never wraps inside a job.
      if (!w_last_pass) begin
        r_pass <= r_pass + 1'b1;
      end
    end
  end

`ifdef SORT_EARLY_EXIT_EN
  // Remember whether the previous pass of this job was swap-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_clean <= 1'b0;
    end else if (w_load) begin
      r_prev_clean <= 1'b0;
    end else if (r_state == S_SORT) begin
      r_prev_clean <= !w_any_swap;
    end
  end
`endif

  // Pack element registers onto the output bus; meaningful only with out_valid.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < N; i++) begin
      out_data[W*i +: W] = r_e[i];
    end
  end

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_sort_n_seq.sv
module tb_sort_n_seq;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int NW = N * W;
`ifdef SORT_EARLY_EXIT_EN
  localparam bit EARLY   = 1'b1;
  localparam int LAT_PRE = 2;
`else
  localparam bit EARLY   = 1'b0;
  localparam int LAT_PRE = 4;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          desc = 1'b0;
  logic          out_ready = 1'b0;
  logic [NW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic          busy;
  logic [NW-1:0] out_data;

  int n_chk = 0;
  int n_fail = 0;
  int n_xfer = 0;

  always #5 clk = ~clk;

  sort_n_seq #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .desc     (desc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference result: stable bubble sort of the unpacked elements.
  function automatic logic [NW-1:0] ref_sort(input logic [NW-1:0] d, input logic ds);
    int v[N];
    int t;
    logic [NW-1:0] r;
    for (int i = 0; i < N; i++) v[i] = int'(d[W*i +: W]);
    for (int a = 0; a < N; a++) begin
      for (int b = 0; b < N - 1 - a; b++) begin
        if (ds ? (v[b] < v[b+1]) : (v[b] > v[b+1])) begin
          t = v[b]; v[b] = v[b+1]; v[b+1] = t;
        end
      end
    end
    r = '0;
    for (int i = 0; i < N; i++) r[W*i +: W] = W'(v[i]);
    return r;
  endfunction

  // Reference latency in edges after the load edge: N, or fewer with early exit.
  function automatic int ref_lat(input logic [NW-1:0] d, input logic ds);
    int v[N];
    int t;
    int sw;
    int prev;
    for (int i = 0; i < N; i++) v[i] = int'(d[W*i +: W]);
    prev = -1;
    for (int p = 0; p < N; p++) begin
      sw = 0;
      for (int i = p % 2; i < N - 1; i += 2) begin
        if (ds ? (v[i] < v[i+1]) : (v[i] > v[i+1])) begin
          t = v[i]; v[i] = v[i+1]; v[i+1] = t;
          sw++;
        end
      end
      if (EARLY && p > 0 && sw == 0 && prev == 0) return p + 1;
      prev = sw;
    end
    return N;
  endfunction

  // Transaction-level model: idle / counting down / holding a result.
  bit            m_busy = 1'b0;
  bit            m_done = 1'b0;
  int            m_cnt = 0;
  logic [NW-1:0] m_exp = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_cnt  = 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy = 1'b1;
        m_cnt  = ref_lat(in_data, desc);
        m_exp  = ref_sort(in_data, desc);
      end
    end else if (!m_done) begin
      m_cnt--;
      if (m_cnt == 0) m_done = 1'b1;
    end else if (out_ready) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      n_xfer++;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", out_valid, m_done);
      chk("in_ready", in_ready, !m_busy);
      chk("busy", busy, m_busy);
      if (m_done) chk("out_data", out_data, m_exp);
    end
  end

  task automatic wait_idle(input string nm);
    int b;
    b = 0;
    while (!in_ready && b < 50) begin
      @(negedge clk);
      b++;
    end
    if (!in_ready) chk({nm, "_idle_timeout"}, in_ready, 1);
  endtask

  task automatic load(input logic [NW-1:0] d, input logic ds);
    @(negedge clk); #2;
    in_valid = 1'b1;
    in_data  = d;
    desc     = ds;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_job(input logic [NW-1:0] d, input logic ds, input logic [NW-1:0] exp,
                         input int lat, input string nm);
    int cyc;
    wait_idle(nm);
    load(d, ds);
    wait_valid(cyc);
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_latency"}, cyc, lat);
    chk({nm, "_data"}, out_data, exp);
    @(negedge clk); #2;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_drop"}, out_valid, 0);
  endtask

  initial begin
    int  cyc;
    bit  seen;

    // Pin the model with hand-computed values.
    chk("model_asc", ref_sort(16'h0E39, 1'b0), 16'hE930);
    chk("model_desc_dup", ref_sort(16'h5255, 1'b1), 16'h2555);
    chk("model_desc", ref_sort(16'h0E39, 1'b1), 16'h039E);
    chk("model_lat_presorted", ref_lat(16'h4321, 1'b0), LAT_PRE);
    chk("model_lat_reverse", ref_lat(16'h1234, 1'b0), 4);

    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);

    // Directed jobs.
    run_job(16'h0E39, 1'b0, 16'hE930, N, "asc");
    run_job(16'h5255, 1'b1, 16'h2555, N, "desc_dup");
    run_job(16'h0E39, 1'b1, 16'h039E, N, "desc");
    run_job(16'h4321, 1'b0, 16'h4321, LAT_PRE, "presorted");
    run_job(16'h1234, 1'b0, 16'h4321, N, "reverse");

    // Backpressure: result held ten cycles, a stray load is ignored.
    wait_idle("bp");
    load(16'hA1C7, 1'b0);
    wait_valid(cyc);
    chk("bp_latency", cyc, N);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      in_valid = (k == 3);
      in_data  = 16'h0F0F;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", out_data, 16'hCA71);
      chk("bp_in_ready", in_ready, 0);
    end
    @(negedge clk); #2;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("bp_no_ghost_job", busy, 0);

    // Reset two cycles into a sort.
    wait_idle("rst_sort");
    load(16'h0E39, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_sort_valid", out_valid, 0);
    chk("rst_sort_busy", busy, 0);
    chk("rst_sort_data", out_data, 0);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("rst_sort_no_output", seen, 0);
    @(negedge clk); #2 rst = 1'b0;
    #1;
    chk("rst_sort_in_ready", in_ready, 1);
    run_job(16'h0E39, 1'b0, 16'hE930, N, "after_rst");

    // Asynchronous reset mid-cycle while holding a result.
    wait_idle("rst_done");
    load(16'h1234, 1'b0);
    wait_valid(cyc);
    @(negedge clk); #3 rst = 1'b1;
    #1;
    chk("rst_done_valid", out_valid, 0);
    chk("rst_done_data", out_data, 0);
    chk("rst_done_busy", busy, 0);
    @(negedge clk); #2 rst = 1'b0;
    #1;
    chk("rst_done_in_ready", in_ready, 1);

    // Random traffic, checked every cycle by the compare process.
    n_xfer = 0;
    repeat (3000) begin
      @(negedge clk); #2;
      in_valid  = $urandom_range(0, 1) == 1;
      in_data   = NW'($urandom);
      desc      = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 3) != 0;
    end
    @(negedge clk); #2;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("random_transfers", n_xfer > 100, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sort_n_seq.md
Name: sort_n_seq

Overview:
- Parametrised sequential sorter and successor to the combinational 4-element sorter.
- Accepts N unsigned W-bit elements in one parallel load, sorts them iteratively in place with odd-even transposition passes (one pass per clock), then presents the sorted vector.
- Sort direction is selectable per job. Valid/ready handshakes on both sides let it sit between pipeline stages.

Parameters:
- N, 4, element count; N >= 2 required.
- W, 4, element width in bits, unsigned.
- CNT_W, $clog2(N+1), pass-counter width (localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  load request
- in_ready  output  1  block can accept a job
- in_data  input  N*W  element i at in_data[W*i +: W]
- desc  input  1  0 = ascending, 1 = descending; sampled only on load
- out_valid  output  1  sorted result available
- out_ready  input  1  consumer accepts result
- out_data  output  N*W  sorted element i at out_data[W*i +: W]
- busy  output  1  high in SORT or DONE

Behaviour:
- Reset (asynchronous, active-high):
  - Enters IDLE; element registers, pass counter and latched desc cleared to 0.
  - out_valid=0, out_data=0, busy=0, in_ready=1 while rst is low and state is IDLE.
  - Reset mid-SORT or mid-DONE abandons the job; no partial output is presented.
- FSM states: IDLE, SORT, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE. Both are decoded from state (registered).
- IDLE:
  - On in_valid && in_ready at an edge: capture in_data into element registers, latch desc, clear pass counter, go to SORT.
  - in_valid in any other state is ignored; no queueing.
- SORT, one pass per clock, pass index p = 0..N-1:
  - p even: compare pairs (0,1),(2,3),...
  - p odd: compare pairs (1,2),(3,4),...
  - An unpaired last element is untouched.
  - Ascending: swap when e[i] > e[i+1]. Descending: swap when e[i] < e[i+1].
  - Equal elements are never swapped, so the sort is stable.
  - After the pass with p = N-1 completes, go to DONE.
  - Time in SORT is exactly N cycles.
- Latency: load at edge t0; passes at edges t0+1..t0+N; out_valid high from edge t0+N onward.
- DONE:
  - out_data = element registers, held stable while out_valid && !out_ready.
  - On out_ready high at an edge, go to IDLE and drop out_valid. in_ready rises the same edge.
  - A new load is possible at the following edge, so there is a minimum of 1 idle cycle between jobs.
  - out_data retains the last result after leaving DONE; it is only valid with out_valid.
- Arithmetic: unsigned comparisons over full W bits. No width growth.
- Pass counter saturates logic: it never wraps within a job.

Optional Feature:
- Macro: SORT_EARLY_EXIT_EN.
- Defined:
  - Each pass records a swap flag.
  - If two consecutive passes both perform zero swaps, go to DONE after the second; the array is provably sorted at that point.
  - Otherwise exit at p = N-1 as usual. Minimum time in SORT is 2 cycles.
  - Result is identical to the non-early-exit result.
- Undefined: swap-flag logic is absent and SORT always takes exactly N cycles.

Test Plan:
- Reset and idle:
  - Assert rst mid-cycle with no clock running -> outputs go to 0 immediately and in_ready=1 after release.
  - With in_valid=0, state remains IDLE and busy=0.
- Ascending sort, N=4, W=4:
  - in_data=16'h0E39 (9,3,14,0), desc=0 -> out_data=16'hE930 (0,3,9,14).
  - out_valid rises exactly 4 edges after the load edge.
- Descending with duplicates:
  - in_data=16'h5255 (5,5,2,5), desc=1 -> out_data=16'h2555 (5,5,5,2).
  - in_data=16'h0E39, desc=1 -> 16'h039E.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0, and a second in_valid pulse is ignored. Release -> one transfer, then IDLE.
- Reset mid-sort: assert rst 2 cycles after load -> out_valid never asserts, in_ready=1 after release, and the next job sorts correctly.
- Early exit (macro defined):
  - Pre-sorted 16'h4321, desc=0 -> out_valid 2 edges after load; with macro undefined -> 4 edges.
  - Both cases give out_data=16'h4321.
  - Reverse input 16'h1234 -> 4 edges in both builds, out_data=16'h4321.
